// File: rtl/mem_rw_arbiter_pkg.sv
// Shared types and widths for the memory read/write arbiter and its
// read-response tracking FIFO.
package mem_rw_arbiter_pkg;

  localparam int MAX_PORTS = 4;
  localparam int PORT_ID_W = 2;
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int RLEN_W    = 5;
  localparam int WBE_W     = 4;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [PORT_ID_W-1:0] id;
    logic [RLEN_W-1:0]    rlen;
  } resp_entry_t;

  localparam int ENTRY_W = $bits(resp_entry_t);

  function automatic logic [MAX_PORTS-1:0] port_onehot(input logic [PORT_ID_W-1:0] id);
    return MAX_PORTS'(1) << id;
  endfunction

endpackage

// File: rtl/mem_rw_resp_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module mem_rw_resp_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between NUM_PORTS
// requesters; read beats are steered back through an in-order tracking FIFO.
module mem_rw_arbiter
  import mem_rw_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             up_request,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] up_addr,
  input  logic [NUM_PORTS-1:0]             up_rnw,
  input  logic [NUM_PORTS-1:0][RLEN_W-1:0] up_rlen,
  input  logic [NUM_PORTS-1:0][WBE_W-1:0]  up_wbe,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] up_wdata,
  output logic [NUM_PORTS-1:0]             up_ack,
  output logic [NUM_PORTS-1:0]             up_rvalid,
  output logic [DATA_W-1:0]                up_rdata,
  output logic                             up_write_outstanding,
  output logic                             mem_request,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic                             mem_rnw,
  output logic [RLEN_W-1:0]                mem_rlen,
  output logic [WBE_W-1:0]                 mem_wbe,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_ack,
  input  logic                             mem_rvalid,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_write_outstanding
);

  // Handshake: a requester holds request and fields stable until it sees a
  // one-cycle ack; the downstream accepts in any cycle where mem_request and
  // mem_ack are both high, so a grant may complete in the cycle it is issued.

  arb_state_t           state_q, state_d;
  logic [PORT_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_ID_W-1:0] lock_id_q, lock_id_d;
  logic [RLEN_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic [MAX_PORTS-1:0] eligible;
  logic                 found;
  logic [PORT_ID_W-1:0] win_id, sel_id, next_ptr;
  logic [PORT_ID_W:0]   cand;

  logic                 sel_req, sel_rnw;
  logic [ADDR_W-1:0]    sel_addr;
  logic [RLEN_W-1:0]    sel_rlen;
  logic [WBE_W-1:0]     sel_wbe;
  logic [DATA_W-1:0]    sel_wdata;

  logic                 ack_fire, beat_fire;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  resp_entry_t          push_entry, head_entry;
  logic [ENTRY_W-1:0]   head_raw;
  logic [MAX_PORTS-1:0] ack_vec, rv_vec;

  // Reads are held back while every tracking slot is in use.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = up_request[p] & ~(up_rnw[p] & fifo_full);
    end
  end

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PORT_ID_W+1)'(i);
      if (cand >= (PORT_ID_W+1)'(NUM_PORTS)) cand = cand - (PORT_ID_W+1)'(NUM_PORTS);
      if (!found && eligible[cand[PORT_ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = cand[PORT_ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_id    = (state_q == ST_LOCKED) ? lock_id_q : win_id;
    sel_req   = 1'b0;
    sel_addr  = '0;
    sel_rnw   = 1'b0;
    sel_rlen  = '0;
    sel_wbe   = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PORT_ID_W'(p) == sel_id) begin
        sel_req   = up_request[p];
        sel_addr  = up_addr[p];
        sel_rnw   = up_rnw[p];
        sel_rlen  = up_rlen[p];
        sel_wbe   = up_wbe[p];
        sel_wdata = up_wdata[p];
      end
    end
    sel_req = sel_req & ~rst & ((state_q == ST_LOCKED) | found);
  end

  assign ack_fire    = sel_req & mem_ack;
  assign mem_request = sel_req;
  assign mem_addr    = sel_req ? sel_addr  : '0;
  assign mem_rnw     = sel_req ? sel_rnw   : 1'b0;
  assign mem_rlen    = sel_req ? sel_rlen  : '0;
  assign mem_wbe     = sel_req ? sel_wbe   : '0;
  assign mem_wdata   = sel_req ? sel_wdata : '0;

  assign up_write_outstanding = ~rst & (mem_write_outstanding | (sel_req & ~sel_rnw));

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    next_ptr  = (sel_id == PORT_ID_W'(NUM_PORTS - 1)) ? '0 : sel_id + PORT_ID_W'(1);
    case (state_q)
      ST_ARB: begin
        if (found && !mem_ack) begin
          state_d   = ST_LOCKED;
          lock_id_d = win_id;
        end
      end
      ST_LOCKED: begin
        if (ack_fire) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
    if (ack_fire) rr_ptr_d = next_ptr;
  end

  always_comb begin
    ack_vec = port_onehot(sel_id);
    up_ack  = ack_fire ? ack_vec[NUM_PORTS-1:0] : '0;
  end

  assign fifo_push       = ack_fire & sel_rnw;
  assign push_entry.id   = sel_id;
  assign push_entry.rlen = sel_rlen;
  assign head_entry      = resp_entry_t'(head_raw);

  // Beats only route while tracking state is valid; the last beat pops.
  assign beat_fire = mem_rvalid & ~fifo_empty & ~rst;
  assign fifo_pop  = beat_fire & (beat_cnt_q == head_entry.rlen);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (fifo_pop)       beat_cnt_d = '0;
    else if (beat_fire) beat_cnt_d = beat_cnt_q + RLEN_W'(1);
  end

  always_comb begin
    rv_vec    = port_onehot(head_entry.id);
    up_rvalid = beat_fire ? rv_vec[NUM_PORTS-1:0] : '0;
  end

  assign up_rdata = rst ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  mem_rw_resp_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .head_o     (head_raw),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  a_no_orphan_beat: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && fifo_empty));

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Self-checking bench for mem_rw_arbiter with two ports and a 4-deep
// response FIFO; grants and read beats are scoreboarded against queues.
module tb_mem_rw_arbiter;
  import mem_rw_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        up_request;
  logic [1:0][29:0]  up_addr;
  logic [1:0]        up_rnw;
  logic [1:0][4:0]   up_rlen;
  logic [1:0][3:0]   up_wbe;
  logic [1:0][31:0]  up_wdata;
  logic [1:0]        up_ack;
  logic [1:0]        up_rvalid;
  logic [31:0]       up_rdata;
  logic              up_write_outstanding;
  logic              mem_request;
  logic [29:0]       mem_addr;
  logic              mem_rnw;
  logic [4:0]        mem_rlen;
  logic [3:0]        mem_wbe;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_write_outstanding;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  ack_seen = '0;
  logic [0:0]  exp_grant_q[$];
  logic [32:0] exp_beat_q[$];

  always #5 clk = ~clk;

  mem_rw_arbiter #(.NUM_PORTS(2), .RESP_DEPTH(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .up_request           (up_request),
    .up_addr              (up_addr),
    .up_rnw               (up_rnw),
    .up_rlen              (up_rlen),
    .up_wbe               (up_wbe),
    .up_wdata             (up_wdata),
    .up_ack               (up_ack),
    .up_rvalid            (up_rvalid),
    .up_rdata             (up_rdata),
    .up_write_outstanding (up_write_outstanding),
    .mem_request          (mem_request),
    .mem_addr             (mem_addr),
    .mem_rnw              (mem_rnw),
    .mem_rlen             (mem_rlen),
    .mem_wbe              (mem_wbe),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .mem_write_outstanding(mem_write_outstanding)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq(tag, {up_ack, up_rvalid, up_rdata, up_write_outstanding, mem_request,
                   mem_addr, mem_rnw, mem_rlen, mem_wbe, mem_wdata}, '0);
  endtask

  // Requesters drop their request in the cycle after they were acked.
  task automatic tick();
    @(posedge clk);
    #1;
    up_request = up_request & ~ack_seen;
  endtask

  task automatic set_port(input int p, input logic [29:0] a, input logic rnw,
                          input logic [4:0] rlen, input logic [31:0] wd);
    up_addr[p]    = a;
    up_rnw[p]     = rnw;
    up_rlen[p]    = rlen;
    up_wbe[p]     = rnw ? 4'h0 : 4'hF;
    up_wdata[p]   = wd;
    up_request[p] = 1'b1;
  endtask

  task automatic send_beat(input logic port, input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    exp_beat_q.push_back({port, d});
  endtask

  // Scoreboard: every ack and read beat must match the next expectation.
  always @(negedge clk) begin
    logic [0:0]  eg;
    logic [32:0] eb;
    if (rst) begin
      ack_seen = '0;
    end else begin
      ack_seen = up_ack;
      if (up_ack != 2'b00) begin
        if (exp_grant_q.size() == 0) begin
          check_eq("ack_unexpected", up_ack, 2'b00);
        end else begin
          eg = exp_grant_q.pop_front();
          check_eq("ack_port", up_ack, 2'b01 << eg);
        end
      end
      if (up_rvalid != 2'b00) begin
        if (exp_beat_q.size() == 0) begin
          check_eq("rvalid_unexpected", up_rvalid, 2'b00);
        end else begin
          eb = exp_beat_q.pop_front();
          check_eq("rvalid_port", up_rvalid, 2'b01 << eb[32]);
          check_eq("rdata", up_rdata, eb[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    up_request = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    up_request = '0; up_addr = '0; up_rnw = '0; up_rlen = '0; up_wbe = '0; up_wdata = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_write_outstanding = 1'b0;

    // Reset state
    @(negedge clk);
    check_outs_zero("rst_outs_zero");
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_outs_zero("post_rst_outs_zero");
    check_eq("rst_state", dut.state_q, ST_ARB);
    check_eq("rst_rr_ptr", dut.rr_ptr_q, 0);
    check_eq("rst_fifo_empty", dut.fifo_empty, 1);

    // Single read, ack two cycles after the request
    tick();
    set_port(0, 30'h100, 1'b1, 5'd0, 32'h0);
    exp_grant_q.push_back(1'b0);
    @(negedge clk);
    check_eq("t1_mem_req", mem_request, 1);
    check_eq("t1_mem_addr", mem_addr, 30'h100);
    check_eq("t1_mem_rnw", mem_rnw, 1);
    tick();
    @(negedge clk);
    check_eq("t1_locked", dut.state_q, ST_LOCKED);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    check_eq("t1_ack", up_ack, 2'b01);
    tick();
    mem_ack = 1'b0;
    send_beat(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("t1_rvalid", up_rvalid, 2'b01);
    check_eq("t1_rdata", up_rdata, 32'hDEADBEEF);
    tick();
    mem_rvalid = 1'b0;
    mem_write_outstanding = 1'b1;
    @(negedge clk);
    check_eq("t1_fifo_empty", dut.fifo_empty, 1);
    check_eq("t1_wo_passthru", up_write_outstanding, 1);
    check_eq("t1_no_req", mem_request, 0);
    mem_write_outstanding = 1'b0;

    // Contention with acks every cycle: expect 0,1,0,1
    do_reset();
    set_port(0, 30'h0A0, 1'b0, 5'd0, 32'h1111_0000);
    set_port(1, 30'h0B0, 1'b0, 5'd0, 32'h2222_0000);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_grant_q.push_back(1'(k % 2));
      @(negedge clk);
      check_eq("t2_mem_addr", mem_addr, (k % 2 == 0) ? 30'h0A0 : 30'h0B0);
      check_eq("t2_write_out", up_write_outstanding, 1);
      tick();
      up_request = 2'b11;
    end
    up_request = '0;
    mem_ack    = 1'b0;
    @(negedge clk);
    check_eq("t2_rr_ptr", dut.rr_ptr_q, 0);

    // Lock on port 1 while port 0 waits
    tick();
    set_port(1, 30'h3C1, 1'b0, 5'd0, 32'hCAFE_0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_lock_addr", mem_addr, 30'h3C1);
      check_eq("t3_lock_wdata", mem_wdata, 32'hCAFE_0001);
      tick();
      set_port(0, 30'h3C0, 1'b0, 5'd0, 32'hCAFE_0000);
    end
    mem_ack = 1'b1;
    exp_grant_q.push_back(1'b1);
    @(negedge clk);
    check_eq("t3_ack_p1", up_ack, 2'b10);
    tick();
    exp_grant_q.push_back(1'b0);
    @(negedge clk);
    check_eq("t3_p0_addr", mem_addr, 30'h3C0);
    check_eq("t3_ack_p0", up_ack, 2'b01);
    tick();
    mem_ack = 1'b0;

    // Two bursts acked before data, returned in order
    set_port(0, 30'h400, 1'b1, 5'd7, 32'h0);
    mem_ack = 1'b1;
    exp_grant_q.push_back(1'b0);
    tick();
    set_port(1, 30'h500, 1'b1, 5'd3, 32'h0);
    exp_grant_q.push_back(1'b1);
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      send_beat((k < 8) ? 1'b0 : 1'b1, $urandom);
      @(negedge clk);
      check_eq("t4_route", up_rvalid, (k < 8) ? 2'b01 : 2'b10);
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("t4_beat_cnt", dut.beat_cnt_q, 0);
    check_eq("t4_fifo_empty", dut.fifo_empty, 1);

    // FIFO full: reads held, writes pass, push+pop together
    for (int k = 0; k < 4; k++) begin
      set_port(0, 30'h200 + 30'(k), 1'b1, 5'd0, 32'h0);
      mem_ack = 1'b1;
      exp_grant_q.push_back(1'b0);
      tick();
    end
    set_port(0, 30'h300, 1'b1, 5'd0, 32'h0);
    set_port(1, 30'h310, 1'b0, 5'd0, 32'h55AA_55AA);
    exp_grant_q.push_back(1'b1);
    @(negedge clk);
    check_eq("t5_full", dut.fifo_full, 1);
    check_eq("t5_write_addr", mem_addr, 30'h310);
    check_eq("t5_write_rnw", mem_rnw, 0);
    tick();
    @(negedge clk);
    check_eq("t5_read_held", mem_request, 0);
    tick();
    mem_ack = 1'b0;
    send_beat(1'b0, 32'hA000_0000);
    @(negedge clk);
    check_eq("t5_held_during_pop", mem_request, 0);
    tick();
    mem_ack = 1'b1;
    send_beat(1'b0, 32'hA000_0001);
    exp_grant_q.push_back(1'b0);
    @(negedge clk);
    check_eq("t5_read_addr", mem_addr, 30'h300);
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      send_beat(1'b0, d);
      @(negedge clk);
      if (k == 0) begin
        check_eq("t5_occupancy", 3'(dut.u_resp_fifo.wr_ptr_q - dut.u_resp_fifo.rd_ptr_q), 3);
        check_eq("t5_not_full", dut.fifo_full, 0);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("t5_fifo_empty", dut.fifo_empty, 1);

    // Reset during the third beat of an 8-beat burst
    tick();
    set_port(1, 30'h600, 1'b1, 5'd7, 32'h0);
    mem_ack = 1'b1;
    exp_grant_q.push_back(1'b1);
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_beat(1'b1, $urandom);
      tick();
    end
    rst        = 1'b1;
    up_request = '0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    check_outs_zero("t6_rst_outs_zero");
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    @(negedge clk);
    check_outs_zero("t6_post_rst_zero");
    check_eq("t6_fifo_empty", dut.fifo_empty, 1);
    check_eq("t6_beat_cnt", dut.beat_cnt_q, 0);
    tick();
    set_port(0, 30'h700, 1'b1, 5'd1, 32'h0);
    mem_ack = 1'b1;
    exp_grant_q.push_back(1'b0);
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_beat(1'b0, 32'h7000_0000 + 32'(k));
      @(negedge clk);
      check_eq("t6_new_route", up_rvalid, 2'b01);
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("t6_end_empty", dut.fifo_empty, 1);

    check_eq("grant_q_left", exp_grant_q.size(), 0);
    check_eq("beat_q_left", exp_beat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
